// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers operands/opcode onto a combinational ALU, holds them for
// SETTLE cycles, then returns the masked result over a valid/ready response handshake.
module alu_op_sequencer #(
  parameter int N      = 2,
  parameter int SETTLE = 1   // legal range 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_select,
  input  logic [N-1:0] alu_dataout,
  input  logic         alu_compare,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_compare,
  output logic         rsp_error,
  output logic [7:0]   op_count
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_INCRA = 3'b010;
  localparam logic [2:0] OP_LT    = 3'b100;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t       state, state_next;
  logic [3:0]   settle_cnt, settle_cnt_next;
  logic [N-1:0] alu_a_next, alu_b_next, rsp_data_next;
  logic [2:0]   alu_select_next;
  logic         rsp_compare_next, rsp_error_next;
  logic [7:0]   op_count_next;
  logic         op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      OP_XOR, OP_INCRA, OP_LT: op_legal = 1'b1;
      default:                 op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= 4'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_select  <= OP_NONE;
      rsp_data    <= '0;
      rsp_compare <= 1'b0;
      rsp_error   <= 1'b0;
      op_count    <= 8'd0;
    end else begin
      state       <= state_next;
      settle_cnt  <= settle_cnt_next;
      alu_a       <= alu_a_next;
      alu_b       <= alu_b_next;
      alu_select  <= alu_select_next;
      rsp_data    <= rsp_data_next;
      rsp_compare <= rsp_compare_next;
      rsp_error   <= rsp_error_next;
      op_count    <= op_count_next;
    end
  end

  // Illegal opcodes skip WAIT entirely and never reach the ALU select lines.
  always_comb begin
    state_next       = state;
    settle_cnt_next  = settle_cnt;
    alu_a_next       = alu_a;
    alu_b_next       = alu_b;
    alu_select_next  = alu_select;
    rsp_data_next    = rsp_data;
    rsp_compare_next = rsp_compare;
    rsp_error_next   = rsp_error;
    op_count_next    = op_count;
    cmd_ready        = 1'b0;
    rsp_valid        = 1'b0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          alu_a_next = cmd_a;
          alu_b_next = cmd_b;
          if (op_legal) begin
            alu_select_next = cmd_op;
            settle_cnt_next = SETTLE_LOAD;
            state_next      = S_WAIT;
          end else begin
            alu_select_next  = OP_NONE;
            rsp_error_next   = 1'b1;
            rsp_data_next    = '0;
            rsp_compare_next = 1'b0;
            state_next       = S_RESP;
          end
        end
      end

      S_WAIT: begin
        if (settle_cnt == 4'd0) begin
          rsp_error_next = 1'b0;
          // Only the field meaningful for the opcode is passed; the other is zeroed.
          if (alu_select == OP_LT) begin
            rsp_data_next    = '0;
            rsp_compare_next = alu_compare;
          end else begin
            rsp_data_next    = alu_dataout;
            rsp_compare_next = 1'b0;
          end
          state_next = S_RESP;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          op_count_next   = op_count + 8'd1;
          alu_select_next = OP_NONE;
          state_next      = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule
